// File: rtl/regfile_mp.sv
// Parametrised register file with NUM_RD combinational read ports and a clear sequencer.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to matching read ports.
module regfile_mp #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk_enable,
  input  logic                     clear,
  output logic                     busy,
  input  logic [NUM_RD*ADDR_W-1:0] r_addr,
  output logic [NUM_RD*WIDTH-1:0]  r_data,
  input  logic                     w_enable,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic [WIDTH-1:0]         w_data,
  output logic [ADDR_W-1:0]        dbg_idx
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_nxt;
  logic              wr_ok;

  logic [WIDTH-1:0]  mem [DEPTH];

  // Register 0 is never written from the port; it reads as zero regardless.
  assign wr_ok = clk_enable && w_enable && (w_addr != '0) && (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CLEAR;
      idx   <= '0;
    end else if (clk_enable) begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_CLEAR: begin
        if (idx == ADDR_W'(DEPTH - 1)) begin
          state_nxt = S_IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + ADDR_W'(1);
        end
      end
      S_IDLE: begin
        if (clear) begin
          state_nxt = S_CLEAR;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_CLEAR;
        idx_nxt   = '0;
      end
    endcase
  end

  // The array has no reset; the sweep zeroes it one entry per enabled cycle.
  always_ff @(posedge clk) begin
    if (clk_enable) begin
      if (state == S_CLEAR) begin
        mem[idx] <= '0;
      end else if (wr_ok) begin
        mem[w_addr] <= w_data;
      end
    end
  end

  assign busy    = (state == S_CLEAR);
  assign dbg_idx = idx;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [WIDTH-1:0]  rd;

    assign ra = r_addr[k*ADDR_W +: ADDR_W];

    // Reads are masked for the whole sweep, so partially cleared contents never leak.
    always_comb begin
      rd = '0;
      if (!busy && (ra != '0)) begin
        rd = mem[ra];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (ra == w_addr)) begin
          rd = w_data;
        end
`endif
      end
    end

    assign r_data[k*WIDTH +: WIDTH] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp (3 read ports) against an array-based reference model.
// Builds with or without REGFILE_BYPASS_EN; the model follows the same macro.
module tb_regfile_mp;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 3;
  localparam int ADDR_W = 5;
  localparam int PW     = 1 + ADDR_W + NUM_RD*WIDTH;

  logic                     clk;
  logic                     rst_n;
  logic                     clk_enable;
  logic                     clear;
  logic                     busy;
  logic [NUM_RD*ADDR_W-1:0] r_addr;
  logic [NUM_RD*WIDTH-1:0]  r_data;
  logic                     w_enable;
  logic [ADDR_W-1:0]        w_addr;
  logic [WIDTH-1:0]         w_data;
  logic [ADDR_W-1:0]        dbg_idx;

  regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_enable (clk_enable),
    .clear      (clear),
    .busy       (busy),
    .r_addr     (r_addr),
    .r_data     (r_data),
    .w_enable   (w_enable),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .dbg_idx    (dbg_idx)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Contents plus "enabled cycles of sweep remaining"; zero remaining means idle.
  logic [WIDTH-1:0] model_mem [DEPTH];
  int               busy_left;
  bit               in_reset;

  function automatic void model_zero();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endfunction

  function automatic logic [PW-1:0] expect_pkt();
    logic [NUM_RD*WIDTH-1:0] rd;
    logic [ADDR_W-1:0]       a;
    logic [WIDTH-1:0]        v;
    logic                    b;
    logic [ADDR_W-1:0]       ix;
    b  = in_reset || (busy_left > 0);
    ix = b ? ADDR_W'(DEPTH - busy_left) : '0;
    rd = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      a = r_addr[k*ADDR_W +: ADDR_W];
      v = '0;
      if (!b && a != 0) begin
        v = model_mem[a];
`ifdef REGFILE_BYPASS_EN
        if (clk_enable && w_enable && w_addr != 0 && a == w_addr) v = w_data;
`endif
      end
      rd[k*WIDTH +: WIDTH] = v;
    end
    return {b, ix, rd};
  endfunction

  function automatic void model_edge();
    if (in_reset || !clk_enable) return;
    if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (w_enable && w_addr != 0) model_mem[w_addr] = w_data;
      if (clear) begin
        model_zero();
        busy_left = DEPTH;
      end
    end
  endfunction

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q [$];
  string         tag_q [$];
  int            checks = 0;
  int            errors = 0;

  always @(negedge clk) begin
    logic [PW-1:0] exp_v;
    logic [PW-1:0] got_v;
    string         t;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      t     = tag_q.pop_front();
      got_v = {busy, dbg_idx, r_data};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s @%0t: got busy/idx/data=%h required %h", t, $time, got_v, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge: apply inputs, queue expected outputs, advance one edge.
  task automatic drive(input bit ce, input bit clr, input bit we,
                       input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd,
                       input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                       input logic [ADDR_W-1:0] a2, input string tag);
    clk_enable = ce;
    clear      = clr;
    w_enable   = we;
    w_addr     = wa;
    w_data     = wd;
    r_addr     = {a2, a1, a0};
    exp_q.push_back(expect_pkt());
    tag_q.push_back(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_rand(input int ce_pct, input int clr_pct, input string tag);
    logic [ADDR_W-1:0] wa;
    wa = ADDR_W'($urandom_range(0, DEPTH-1));
    drive($urandom_range(0, 99) < ce_pct, $urandom_range(0, 99) < clr_pct,
          $urandom_range(0, 1) == 1, wa, $urandom,
          ADDR_W'($urandom_range(0, DEPTH-1)),
          ($urandom_range(0, 2) == 0) ? wa : ADDR_W'($urandom_range(0, DEPTH-1)),
          ADDR_W'($urandom_range(0, DEPTH-1)), tag);
  endtask

  task automatic assert_reset();
    rst_n     = 1'b0;
    in_reset  = 1'b1;
    busy_left = DEPTH;
    model_zero();
  endtask

  task automatic release_reset();
    rst_n    = 1'b1;
    in_reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; clk_enable = 1'b1; clear = 1'b0; w_enable = 1'b0;
    w_addr = '0; w_data = '0; r_addr = '0;
    assert_reset();
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) drive_rand(100, 10, "reset_hold");
    release_reset();

    // Power-up sweep: writes attempted here must be dropped.
    for (int i = 0; i < DEPTH; i++) drive_rand(100, 20, "power_sweep");
    drive(1, 0, 0, 0, 0, 1, 2, 3, "post_sweep_zero");

    drive(1, 0, 1, 5,  32'hDEADBEEF, 5, 31, 0, "wr_r5");
    drive(1, 0, 1, 31, 32'h12345678, 5, 31, 0, "wr_r31");
    drive(1, 0, 0, 0,  0,            5, 31, 0, "rd_5_31_0");

    drive(1, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, "wr_r0");
    drive(1, 0, 0, 0, 0,            0, 0, 0, "rd_r0");

    drive(1, 0, 1, 7, 32'h11111111, 0, 0, 0, "pre_r7");
    drive(1, 0, 1, 7, 32'hA5A5A5A5, 5, 7, 7, "bypass_same");
    drive(1, 0, 0, 0, 0,            5, 7, 7, "bypass_after");

    // Stall with clk_enable low in the middle of a sweep.
    for (int i = 1; i < DEPTH; i++)
      drive(1, 0, 1, ADDR_W'(i), $urandom | 32'h1, ADDR_W'(i), ADDR_W'(i-1), 0, "fill");
    drive(1, 1, 1, 3, 32'hCAFEF00D, 3, 4, 5, "clr_req");
    for (int i = 0; i < 15; i++) drive_rand(100, 30, "clr_sweep");
    for (int i = 0; i < 10; i++) drive_rand(0, 30, "clr_stall");
    for (int i = 0; i < DEPTH-15; i++) drive_rand(100, 30, "clr_finish");
    for (int i = 0; i < DEPTH; i++)
      drive(1, 0, 0, 0, 0, ADDR_W'(i), ADDR_W'(i ^ 1), ADDR_W'(DEPTH-1-i), "clr_readback");

    for (int i = 0; i < 400; i++) drive_rand(85, 2, "random_a");

    // Reset during a sweep at idx=12.
    while (busy_left > 0) drive_rand(100, 0, "drain");
    drive(1, 1, 0, 0, 0, 1, 2, 3, "mid_clr_req");
    for (int i = 0; i < 12; i++) drive_rand(100, 0, "mid_sweep");
    assert_reset();
    for (int i = 0; i < 2; i++) drive_rand(100, 0, "rst_mid");
    release_reset();
    for (int i = 0; i < DEPTH + 1; i++) drive_rand(100, 0, "rst_resweep");

    for (int i = 0; i < 300; i++) drive_rand(90, 2, "random_b");

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the CPU datapath, generalising the fixed 32×32, two-read-port file. Depth, width and read-port count are configurable. A built-in clear sequencer zeroes the whole array after reset or on request. An optional write-to-read bypass removes the need for external forwarding muxes in the decode stage.

## Interface
- WIDTH, 32, bits per register
- DEPTH, 32, number of registers; must be a power of two and ≥ 2
- NUM_RD, 2, number of asynchronous read ports; 1–8
- ADDR_W, $clog2(DEPTH), address width; derived, never overridden

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- clk_enable  in  1  global stall; when low, no state changes (array, FSM, counter)
- clear  in  1  synchronous request to zero the entire array
- busy  out  1  high while the clear sequencer runs
- r_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- r_data  out  NUM_RD*WIDTH  read data, port k at bits [k*WIDTH +: WIDTH]
- w_enable  in  1  write strobe
- w_addr  in  ADDR_W  write address
- w_data  in  WIDTH  write data

## Operation
- Register 0 is hardwired to zero: reads of address 0 return 0, and writes to address 0 are discarded.
- Reads are combinational from the array (plus bypass, see Configuration).
- A write occurs on a rising edge with clk_enable=1, w_enable=1, w_addr≠0 and state IDLE.
- The array itself has no reset. Zeroing is done by the FSM instead.
- FSM states:
  - CLEAR: write 0 to entry idx, then idx←idx+1 per enabled cycle. When idx=DEPTH-1 is written, go to IDLE and set idx←0.
  - IDLE: normal operation. clear=1 with clk_enable=1 → CLEAR, idx←0.
- busy = (state==CLEAR), registered.
- While busy:
  - w_enable is ignored (the write is dropped, not queued).
  - All r_data ports return 0, regardless of how far the sweep has progressed.
  - clear is ignored; the sweep is not restarted.

## Timing
- Reset values while rst_n=0: state=CLEAR, idx=0, busy=1. r_data is 0 on all ports.
- After rst_n deasserts, the clear sequence takes exactly DEPTH enabled cycles:
  - busy falls after the edge that writes entry DEPTH-1.
  - The first accepted write is in the following cycle.
- clear sampled at edge N (IDLE, clk_enable=1) → busy=1 after edge N. A write presented in the same cycle as the clear request is still performed; the sweep then zeroes it.
- clk_enable=0 freezes idx and state, so busy stays high indefinitely.
- rst_n asserted mid-sweep or mid-operation immediately forces state=CLEAR and idx=0, and the sweep restarts from entry 0.
- Write latency: data written at edge N is visible on r_data after edge N (combinationally the same cycle when the bypass is enabled).
- Read-during-write to the same address, without bypass, returns the old value until the edge.

## Configuration
- REGFILE_BYPASS_EN defined:
  - For each read port k: if state=IDLE, clk_enable=1, w_enable=1, w_addr≠0 and r_addr[k]==w_addr, then r_data[k]=w_data combinationally.
  - Otherwise r_data[k] reads the array.
- Not defined: r_data always reads the array. Same-cycle read-after-write returns the pre-write value.
- Port widths and all other behaviour are identical in both builds.

## Test plan
- Reset sequence, DEPTH=32: deassert rst_n → busy high for exactly 32 enabled cycles. All reads return 0 during and after the sweep.
- Write/read, NUM_RD=3: write 0xDEADBEEF to r5 and 0x12345678 to r31, then read r5/r31/r0 on ports 0/1/2 → 0xDEADBEEF, 0x12345678, 0.
- Write to r0 with 0xFFFFFFFF → r0 reads 0 on every port.
- Bypass: same-cycle write of 0xA5A5A5A5 to r7 while port 1 reads r7:
  - With REGFILE_BYPASS_EN: port 1 shows 0xA5A5A5A5 in that cycle.
  - Without it: port 1 shows the old value, and 0xA5A5A5A5 appears after the edge.
- Clear and stall: fill r1–r31 with nonzero data, pulse clear, and hold clk_enable=0 for 10 cycles mid-sweep:
  - busy stays high and idx holds during the stall.
  - The sweep finishes 32 enabled cycles after clear, and all entries then read 0.
  - Writes issued during busy are lost.
- Reset mid-sweep: assert rst_n at idx=12 → after release, busy lasts a full 32 enabled cycles.
